// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the chess board store: piece codes, FSM state
// constants, square coordinate field widths and small coordinate helpers.
// A coordinate byte is {row[3:0], col[3:0]}; only rows/cols 0..7 are on board.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned CODE_W  = 6;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned XY_W    = ROW_W + COL_W;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned SQUARES = 64;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [XY_W-1:0]   xy_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // Piece codes
    localparam code_t PC_EMPTY    = 6'd0;
    localparam code_t PC_W_PAWN   = 6'd1;
    localparam code_t PC_W_BISHOP = 6'd2;
    localparam code_t PC_W_KNIGHT = 6'd3;
    localparam code_t PC_W_ROOK   = 6'd4;
    localparam code_t PC_W_QUEEN  = 6'd5;
    localparam code_t PC_W_KING   = 6'd6;
    localparam code_t PC_B_PAWN   = 6'd7;
    localparam code_t PC_B_BISHOP = 6'd8;
    localparam code_t PC_B_KNIGHT = 6'd9;
    localparam code_t PC_B_ROOK   = 6'd10;
    localparam code_t PC_B_QUEEN  = 6'd11;
    localparam code_t PC_B_KING   = 6'd12;

    // Black codes are the white codes shifted by this amount
    localparam code_t PC_BLACK_OFS = 6'd6;

    // FSM states
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_MV_RD = 2'd2;
    localparam logic [1:0] ST_MV_WR = 2'd3;

    // True when either field of the coordinate lies off the 8x8 board
    function automatic logic xy_oob(input xy_t xy);
        return (xy[XY_W-1:COL_W] > ROW_W'(7)) || (xy[COL_W-1:0] > COL_W'(7));
    endfunction

    // Storage index row*8 + col; only meaningful for on-board coordinates
    function automatic idx_t xy_index(input xy_t xy);
        return {xy[COL_W+2:COL_W], xy[2:0]};
    endfunction

endpackage

// File: rtl/board_state_if.sv
// -----------------------------------------------------------------------------
// board_state_if
// Bundles the move handshake, move result and drawing read port of
// board_state.
//   master : drives new_game, move_valid, move_from, move_to, figure_xy
//   slave  : drives move_ready, move_done, move_err, captured_code,
//            figure_code, busy
// -----------------------------------------------------------------------------
interface board_state_if;
    import vga_pkg::*;

    logic  new_game;
    logic  move_valid;
    logic  move_ready;
    xy_t   move_from;
    xy_t   move_to;
    logic  move_done;
    logic  move_err;
    code_t captured_code;
    xy_t   figure_xy;
    code_t figure_code;
    logic  busy;

    modport master (
        output new_game, move_valid, move_from, move_to, figure_xy,
        input  move_ready, move_done, move_err, captured_code, figure_code, busy
    );

    modport slave (
        input  new_game, move_valid, move_from, move_to, figure_xy,
        output move_ready, move_done, move_err, captured_code, figure_code, busy
    );

endinterface

// File: rtl/board_init_rom.sv
// -----------------------------------------------------------------------------
// board_init_rom
// Combinational starting-position table.
//   idx  : square index row*8 + col
//   code : piece code of that square in the starting position
// -----------------------------------------------------------------------------
module board_init_rom
    import vga_pkg::*;
(
    input  idx_t  idx,
    output code_t code
);

    logic [2:0] row;
    logic [2:0] col;
    code_t      back_rank;

    assign row = idx[5:3];
    assign col = idx[2:0];

    // White back rank by column; black uses the same order shifted by 6
    always_comb begin
        back_rank = PC_W_ROOK;
        case (col)
            3'd0:    back_rank = PC_W_ROOK;
            3'd1:    back_rank = PC_W_KNIGHT;
            3'd2:    back_rank = PC_W_BISHOP;
            3'd3:    back_rank = PC_W_QUEEN;
            3'd4:    back_rank = PC_W_KING;
            3'd5:    back_rank = PC_W_BISHOP;
            3'd6:    back_rank = PC_W_KNIGHT;
            default: back_rank = PC_W_ROOK;
        endcase
    end

    always_comb begin
        code = PC_EMPTY;
        case (row)
            3'd0:    code = back_rank + PC_BLACK_OFS;
            3'd1:    code = PC_B_PAWN;
            3'd6:    code = PC_W_PAWN;
            3'd7:    code = back_rank;
            default: code = PC_EMPTY;
        endcase
    end

endmodule

// File: rtl/board_state.sv
// -----------------------------------------------------------------------------
// board_state
// 64 x 6-bit chess board store with a move engine and a registered read port
// for the drawing stage.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset (reloads the board through INIT)
//   bus  : board_state_if.slave
//          new_game            - request reload of the starting position
//          move_valid/ready    - move handshake, ready only in IDLE
//          move_from/move_to   - {row,col} source/destination
//          move_done/move_err  - one-cycle result pulse, err = rejected
//          captured_code       - previous destination code, valid with done
//          figure_xy/code      - read port, 1-cycle latency, 0 off-board
//          busy                - high in INIT, MV_RD and MV_WR
// -----------------------------------------------------------------------------
module board_state
    import vga_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    board_state_if.slave bus
);

    logic [1:0] state;
    idx_t       init_cnt;
    xy_t        from_q;
    xy_t        to_q;
    code_t      src_code;
    code_t      dst_code;

    logic       done_q;
    logic       err_q;
    code_t      cap_q;
    code_t      fig_q;

    // Board storage: no reset, only defined after INIT has run
    code_t      mem [SQUARES];

    code_t      rom_code;
    code_t      rd_src;
    code_t      rd_dst;
    logic       reject;

    board_init_rom u_rom (
        .idx  (init_cnt),
        .code (rom_code)
    );

    // Operand reads for the latched move; off-board indices are masked by
    // the reject term, so whatever they read is never used.
    assign rd_src = mem[xy_index(from_q)];
    assign rd_dst = mem[xy_index(to_q)];
    assign reject = xy_oob(from_q) || xy_oob(to_q) ||
                    (rd_src == PC_EMPTY) || (from_q == to_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            from_q   <= '0;
            to_q     <= '0;
            src_code <= '0;
            dst_code <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cap_q    <= '0;
            fig_q    <= '0;
        end else begin
            done_q <= 1'b0;

            // Nonblocking read: a same-cycle write to this square is seen
            // only on the following cycle.
            fig_q <= xy_oob(bus.figure_xy) ? PC_EMPTY : mem[xy_index(bus.figure_xy)];

            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == IDX_W'(SQUARES - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.new_game) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end else if (bus.move_valid) begin
                        from_q <= bus.move_from;
                        to_q   <= bus.move_to;
                        state  <= ST_MV_RD;
                    end
                end
                ST_MV_RD: begin
                    if (reject) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        cap_q  <= PC_EMPTY;
                        state  <= ST_IDLE;
                    end else begin
                        src_code <= rd_src;
                        dst_code <= rd_dst;
                        state    <= ST_MV_WR;
                    end
                end
                ST_MV_WR: begin
                    done_q <= 1'b1;
                    err_q  <= 1'b0;
                    cap_q  <= dst_code;
                    state  <= ST_IDLE;
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    // While rst is held the state sits in INIT at index 0, so this only
    // rewrites square 0 with its starting value; no move write can land.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= rom_code;
        end else if (state == ST_MV_WR) begin
            mem[xy_index(to_q)]   <= src_code;
            mem[xy_index(from_q)] <= PC_EMPTY;
        end
    end

    assign bus.move_ready    = (state == ST_IDLE);
    assign bus.busy          = (state != ST_IDLE);
    assign bus.move_done     = done_q;
    assign bus.move_err      = err_q;
    assign bus.captured_code = cap_q;
    assign bus.figure_code   = fig_q;

endmodule

// File: tb/tb_board_state.sv
// -----------------------------------------------------------------------------
// tb_board_state
// Self-checking bench for board_state: directed scenarios plus randomized
// moves compared against a square-array model of the board.
// -----------------------------------------------------------------------------
module tb_board_state;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst;

    board_state_if bus ();

    board_state dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int model [64];

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starting position written out row by row
    function automatic int start_code(input int r, input int c);
        int black_back [8] = '{10, 9, 8, 11, 12, 8, 9, 10};
        int white_back [8] = '{4, 3, 2, 5, 6, 2, 3, 4};
        if (r == 0) return black_back[c];
        if (r == 1) return 7;
        if (r == 6) return 1;
        if (r == 7) return white_back[c];
        return 0;
    endfunction

    task automatic model_reload();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                model[r * 8 + c] = start_code(r, c);
    endtask

    function automatic bit off_board(input logic [7:0] xy);
        return (int'(xy[7:4]) > 7) || (int'(xy[3:0]) > 7);
    endfunction

    function automatic int sq(input logic [7:0] xy);
        return int'(xy[7:4]) * 8 + int'(xy[3:0]);
    endfunction

    function automatic int exp_at(input logic [7:0] xy);
        if (off_board(xy)) return 0;
        return model[sq(xy)];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fig"},   bus.figure_code,   0);
        check({tag, "_done"},  bus.move_done,     0);
        check({tag, "_err"},   bus.move_err,      0);
        check({tag, "_cap"},   bus.captured_code, 0);
        check({tag, "_ready"}, bus.move_ready,    0);
        check({tag, "_busy"},  bus.busy,          1);
    endtask

    // Counts falling edges until busy drops; optionally clears the request
    // inputs after the first edge.
    task automatic wait_ready(input string tag, input int exp_cycles, input bit clear_req);
        int  n = 0;
        bit  done_seen = 0;
        do begin
            @(negedge clk);
            n++;
            if (clear_req) begin
                bus.new_game   = 1'b0;
                bus.move_valid = 1'b0;
            end
            if (bus.move_done) done_seen = 1;
        end while (bus.busy && n < 300);
        check({tag, "_len"},     n,              exp_cycles);
        check({tag, "_ready"},   bus.move_ready, 1);
        check({tag, "_nodone"},  done_seen,      0);
    endtask

    task automatic read_sq(input string tag, input logic [7:0] xy, input int exp);
        bus.figure_xy = xy;
        @(negedge clk);
        check(tag, bus.figure_code, exp);
    endtask

    // New address every cycle, each result checked one cycle later
    task automatic scan(input string tag);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] xy;
            xy = {4'(i / 8), 4'(i % 8)};
            bus.figure_xy = xy;
            @(negedge clk);
            check(tag, bus.figure_code, exp_at(xy));
        end
    endtask

    task automatic do_move(input string tag, input logic [7:0] f, input logic [7:0] t,
                           input bit ng_mid);
        int  src;
        int  dst;
        bit  rej;
        int  lat;
        src = exp_at(f);
        dst = exp_at(t);
        rej = off_board(f) || off_board(t) || (src == 0) || (f == t);

        check({tag, "_ready"}, bus.move_ready, 1);
        bus.move_from  = f;
        bus.move_to    = t;
        bus.move_valid = 1'b1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        if (ng_mid) bus.new_game = 1'b1;
        lat = 0;
        while (!bus.move_done && lat < 6) begin
            @(negedge clk);
            bus.new_game = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, lat, rej ? 1 : 2);
        check({tag, "_err"}, bus.move_err, rej ? 1 : 0);
        check({tag, "_cap"}, bus.captured_code, rej ? 0 : dst);
        if (!rej) begin
            model[sq(t)] = src;
            model[sq(f)] = 0;
        end
        @(negedge clk);
        check({tag, "_pulse"}, bus.move_done, 0);
        if (ng_mid) check({tag, "_ngign"}, bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.new_game   = 1'b0;
        bus.move_valid = 1'b0;
        bus.move_from  = '0;
        bus.move_to    = '0;
        bus.figure_xy  = '0;
        model_reload();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_ready("init", 64, 1'b0);

        read_sq("rd04", 8'h04, 12);
        read_sq("rd74", 8'h74, 6);
        read_sq("rd33", 8'h33, 0);
        read_sq("rd80", 8'h80, 0);
        scan("scan_start");

        // Legal move and capture
        do_move("mv64_44", 8'h64, 8'h44, 1'b0);
        read_sq("rd44", 8'h44, 1);
        read_sq("rd64", 8'h64, 0);
        do_move("cap44_13", 8'h44, 8'h13, 1'b0);
        read_sq("rd13", 8'h13, 1);
        read_sq("rd44b", 8'h44, 0);

        // Rejects
        do_move("rej_empty", 8'h33, 8'h43, 1'b0);
        do_move("rej_same",  8'h00, 8'h00, 1'b0);
        do_move("rej_col8",  8'h00, 8'h18, 1'b0);
        do_move("rej_row8",  8'h80, 8'h00, 1'b0);
        scan("scan_rej");

        // new_game raised while the move is in MV_RD is ignored
        do_move("ng_mid", 8'h61, 8'h51, 1'b1);

        // Randomized moves
        for (int k = 0; k < 60; k++) begin
            logic [7:0] f;
            logic [7:0] t;
            f = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            t = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) == 0) f = 8'($urandom);
            if ($urandom_range(0, 9) == 0) t = 8'($urandom);
            if ($urandom_range(0, 14) == 0) t = f;
            do_move("rand", f, t, 1'b0);
        end
        scan("scan_rand");

        // new_game wins over a simultaneous move request
        bus.move_from  = 8'h66;
        bus.move_to    = 8'h46;
        bus.move_valid = 1'b1;
        bus.new_game   = 1'b1;
        wait_ready("prio", 65, 1'b1);
        model_reload();
        scan("scan_prio");

        // Reset while the move engine is in MV_RD
        bus.move_from  = 8'h62;
        bus.move_to    = 8'h42;
        bus.move_valid = 1'b1;
        @(negedge clk);
        bus.move_valid = 1'b0;
        check("mvrd_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check("rst_mid_nodone", bus.move_done, 0);
        rst = 1'b0;
        wait_ready("reinit", 64, 1'b0);
        model_reload();
        scan("scan_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
